// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with standard or first-word-fall-through reads,
// exact occupancy, programmable almost-full/empty, flush and sticky error flags.
module sync_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH       = 8,
  parameter string       FIFO_MODE        = "STD_FIFO",
  parameter int unsigned AFULL_THRESHOLD  = (1 << ADDR_WIDTH) - 1,
  parameter int unsigned AEMPTY_THRESHOLD = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_full,
  output logic                  o_afull,
  output logic                  o_empty,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_cnt,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
  localparam bit          IS_FWFT = (FIFO_MODE == "FWFT");

  // Elaboration-time parameter legality checks
  if (FIFO_MODE != "STD_FIFO" && FIFO_MODE != "FWFT") begin : g_bad_mode
    $error("sync_fifo_ctrl: FIFO_MODE must be \"STD_FIFO\" or \"FWFT\"");
  end
  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 12) begin : g_bad_aw
    $error("sync_fifo_ctrl: ADDR_WIDTH out of range 2..12");
  end
  if (AFULL_THRESHOLD < 1 || AFULL_THRESHOLD > DEPTH) begin : g_bad_af
    $error("sync_fifo_ctrl: AFULL_THRESHOLD out of range 1..DEPTH");
  end
  if (AEMPTY_THRESHOLD > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_ctrl: AEMPTY_THRESHOLD out of range 0..DEPTH-1");
  end

  // FWFT prefetch: output register empty, valid with RAM drained, or valid
  // with the next word available in RAM for an immediate refill on pop.
  typedef enum logic [1:0] {
    ST_EMPTY       = 2'd0,
    ST_VALID       = 2'd1,
    ST_VALID_FETCH = 2'd2
  } fwft_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q;
  logic [ADDR_WIDTH-1:0] rptr_q;
  logic [CNT_W-1:0]      cnt_q;
  fwft_state_e           state_q;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_rd;
  logic                  valid_d;
  logic [CNT_W-1:0]      cnt_d;
  logic [CNT_W-1:0]      ram_words;
  logic [CNT_W-1:0]      ram_after;
  fwft_state_e           state_d;
  logic                  rvalid_d;
  logic                  empty_d;
  logic                  ovf_d;
  logic                  udf_d;

  assign o_cnt = cnt_q;

  // Next-state: acceptance, occupancy, RAM read strobe, prefetch FSM, flags
  always_comb begin
    wr_acc    = i_we & ~o_full;
    rd_acc    = i_re & ~o_empty;
    cnt_d     = cnt_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    ram_words = cnt_q - CNT_W'(state_q != ST_EMPTY);
    ram_rd    = 1'b0;
    valid_d   = 1'b0;
    ram_after = '0;
    state_d   = state_q;
    rvalid_d  = 1'b0;
    empty_d   = 1'b1;
    if (IS_FWFT) begin
      unique case (state_q)
        ST_EMPTY:       ram_rd = (ram_words != '0);
        ST_VALID_FETCH: ram_rd = rd_acc;
        default:        ram_rd = 1'b0;
      endcase
      valid_d   = ram_rd | ((state_q != ST_EMPTY) & ~rd_acc);
      ram_after = ram_words + CNT_W'(wr_acc) - CNT_W'(ram_rd);
      if (!valid_d)             state_d = ST_EMPTY;
      else if (ram_after != '0) state_d = ST_VALID_FETCH;
      else                      state_d = ST_VALID;
      rvalid_d  = valid_d;
      empty_d   = ~valid_d;
    end else begin
      ram_rd   = rd_acc;
      rvalid_d = rd_acc;
      empty_d  = (cnt_d == '0);
      state_d  = ST_EMPTY;
    end
    ovf_d = (o_overflow  & ~i_clr_err) | (i_we & o_full);
    udf_d = (o_underflow & ~i_clr_err) | (i_re & o_empty);
  end

  // Control and status registers; reset outranks flush, flush outranks requests
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      state_q     <= ST_EMPTY;
      o_rvalid    <= 1'b0;
      o_full      <= 1'b0;
      o_afull     <= 1'b0;
      o_empty     <= 1'b1;
      o_aempty    <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_flush) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      state_q     <= ST_EMPTY;
      o_rvalid    <= 1'b0;
      o_full      <= 1'b0;
      o_afull     <= 1'b0;
      o_empty     <= 1'b1;
      o_aempty    <= 1'b1;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + ADDR_WIDTH'(1);
      if (ram_rd) rptr_q <= rptr_q + ADDR_WIDTH'(1);
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      o_rvalid    <= rvalid_d;
      o_full      <= (cnt_d == CNT_W'(DEPTH));
      o_afull     <= (cnt_d >= CNT_W'(AFULL_THRESHOLD));
      o_empty     <= empty_d;
      o_aempty    <= (cnt_d <= CNT_W'(AEMPTY_THRESHOLD));
      o_overflow  <= ovf_d;
      o_underflow <= udf_d;
    end
  end

  // RAM write port; contents survive reset and flush
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && wr_acc) mem[wptr_q] <= i_wdata;
  end

  // RAM read port doubling as the output data register; flush holds it
  always_ff @(posedge i_clk) begin
    if (i_rst)                  o_rdata <= '0;
    else if (!i_flush && ram_rd) o_rdata <= mem[rptr_q];
  end

endmodule
